mat_transform_2pass: RTL and testbench

MAT_TRANSFORM_2PASS -- requirements
Module: mat_transform_2pass

---
 rtl/mat_transform_2pass.sv | 157 +++++++++++++++
 tb/tb_mat_transform_2pass.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_transform_2pass.sv
// Two-pass matrix transform: pass 1 forms X*C^T into a transposed on-chip buffer,
// pass 2 multiplies that buffer by C^T, giving Y = C*X^T*C^T (or X*C^T in single-pass mode).

module mat_transform_2pass_lane #(
  parameter int DW = 8
) (
  input  logic signed [DW-1:0]   a,
  input  logic signed [DW-1:0]   c,
  output logic signed [2*DW-1:0] p
);
  assign p = a * c;
endmodule

module mat_transform_2pass #(
  parameter int N     = 8,
  parameter int DW    = 8,
  parameter int SHIFT = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  output logic [$clog2(N)-1:0] x_addr,
  input  logic [N*DW-1:0]      x_data,
  output logic [$clog2(N)-1:0] c_addr,
  input  logic [N*DW-1:0]      c_data,
  output logic                 y_valid,
  output logic [$clog2(N)-1:0] y_row,
  output logic [$clog2(N)-1:0] y_col,
  output logic [DW-1:0]        y_data,
  output logic                 busy,
  output logic                 done
);
  localparam int LN     = $clog2(N);
  localparam int CW     = 2*LN;
  localparam int ACCW   = 2*DW + LN;
  localparam int STAGES = 2;
  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((2**(DW-1)) - 1);
  localparam logic signed [ACCW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {IDLE, P1, D1, P2, D2, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   mode_q, mode_d;
  logic [STAGES:1]        vld_pipe_q, vld_pipe_d;
  logic [LN-1:0]          s1_row_q, s1_row_d, s1_col_q, s1_col_d;
  logic                   s1_p2_q, s1_p2_d;
  logic [LN-1:0]          y_row_q, y_row_d, y_col_q, y_col_d;
  logic [DW-1:0]          y_data_q, y_data_d;
  logic                   emit_q, emit_d;
  logic [N-1:0][DW-1:0]   t_mem [N];
  logic [N-1:0][DW-1:0]   a_row, c_row;
  logic [N-1:0][2*DW-1:0] prod;
  logic signed [ACCW-1:0] acc, acc_sh, sat_val;
  logic                   issue;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    mode_d  = mode_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = P1;
          mode_d  = mode;
        end
      end
      P1: if (cnt_q == '1) begin state_d = D1; cnt_d = '0; end
      D1: if (cnt_q == CW'(1)) begin state_d = mode_q ? DONE : P2; cnt_d = '0; end
      P2: if (cnt_q == '1) begin state_d = D2; cnt_d = '0; end
      D2: if (cnt_q == CW'(1)) begin state_d = DONE; cnt_d = '0; end
      DONE: begin state_d = IDLE; cnt_d = '0; mode_d = 1'b0; end
      default: begin state_d = IDLE; cnt_d = '0; end
    endcase
  end

  assign issue  = (state_q == P1) || (state_q == P2);
  assign x_addr = (state_q == P1) ? cnt_q[CW-1:LN] : '0;
  assign c_addr = issue ? cnt_q[LN-1:0] : '0;
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);

  // Stage 1 sees the row data one cycle after the address; pass 2 pulls its row from T.
  assign a_row = s1_p2_q ? t_mem[s1_row_q] : x_data;
  assign c_row = c_data;

  for (genvar g = 0; g < N; g++) begin : g_lane
    mat_transform_2pass_lane #(.DW(DW)) u_lane (
      .a(a_row[g]),
      .c(c_row[g]),
      .p(prod[g])
    );
  end

  always_comb begin
    vld_pipe_d = {vld_pipe_q[STAGES-1:1], issue};
    s1_row_d   = cnt_q[CW-1:LN];
    s1_col_d   = cnt_q[LN-1:0];
    s1_p2_d    = (state_q == P2);
    acc        = '0;
    for (int k = 0; k < N; k++) acc = acc + ACCW'($signed(prod[k]));
    acc_sh  = acc >>> SHIFT;
    sat_val = acc_sh;
    if (acc_sh > SAT_MAX)      sat_val = SAT_MAX;
    else if (acc_sh < SAT_MIN) sat_val = SAT_MIN;
    y_data_d = y_data_q;
    y_row_d  = y_row_q;
    y_col_d  = y_col_q;
    emit_d   = emit_q;
    if (vld_pipe_q[1]) begin
      y_data_d = sat_val[DW-1:0];
      y_row_d  = s1_row_q;
      y_col_d  = s1_col_q;
      emit_d   = mode_q | s1_p2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mode_q     <= 1'b0;
      vld_pipe_q <= '0;
      s1_row_q   <= '0;
      s1_col_q   <= '0;
      s1_p2_q    <= 1'b0;
      y_row_q    <= '0;
      y_col_q    <= '0;
      y_data_q   <= '0;
      emit_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      vld_pipe_q <= vld_pipe_d;
      s1_row_q   <= s1_row_d;
      s1_col_q   <= s1_col_d;
      s1_p2_q    <= s1_p2_d;
      y_row_q    <= y_row_d;
      y_col_q    <= y_col_d;
      y_data_q   <= y_data_d;
      emit_q     <= emit_d;
    end
  end

  // Pass-1 results land transposed; the last write retires inside D1, before P2 reads.
  always_ff @(posedge clk) begin
    if (vld_pipe_q[STAGES] && !emit_q) t_mem[y_col_q][y_row_q] <= y_data_q;
  end

  assign y_valid = vld_pipe_q[STAGES] & emit_q;
  assign y_row   = y_row_q;
  assign y_col   = y_col_q;
  assign y_data  = y_data_q;
endmodule

// File: tb/tb_mat_transform_2pass.sv
// Randomized bench: a plain-arithmetic matrix model predicts every output and cycle-exact
// handshake timing for an N=8 instance and an N=4/DW=12/SHIFT=11 instance.
module tb_mat_transform_2pass;
  localparam int NA = 8, DWA = 8,  SHA = 0,  LA = 3;
  localparam int NB = 4, DWB = 12, SHB = 11, LB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_a, mode_a, start_b, mode_b;
  logic [LA-1:0] x_addr_a, c_addr_a, y_row_a, y_col_a;
  logic [NA*DWA-1:0] x_data_a, c_data_a;
  logic [DWA-1:0] y_data_a;
  logic y_valid_a, busy_a, done_a;
  logic [LB-1:0] x_addr_b, c_addr_b, y_row_b, y_col_b;
  logic [NB*DWB-1:0] x_data_b, c_data_b;
  logic [DWB-1:0] y_data_b;
  logic y_valid_b, busy_b, done_b;

  mat_transform_2pass #(.N(NA), .DW(DWA), .SHIFT(SHA)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mode(mode_a),
    .x_addr(x_addr_a), .x_data(x_data_a), .c_addr(c_addr_a), .c_data(c_data_a),
    .y_valid(y_valid_a), .y_row(y_row_a), .y_col(y_col_a), .y_data(y_data_a),
    .busy(busy_a), .done(done_a));

  mat_transform_2pass #(.N(NB), .DW(DWB), .SHIFT(SHB)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mode(mode_b),
    .x_addr(x_addr_b), .x_data(x_data_b), .c_addr(c_addr_b), .c_data(c_data_b),
    .y_valid(y_valid_b), .y_row(y_row_b), .y_col(y_col_b), .y_data(y_data_b),
    .busy(busy_b), .done(done_b));

  longint xm_a[16][16], cm_a[16][16], ey_a[16][16];
  longint xm_b[16][16], cm_b[16][16], ey_b[16][16];
  int cyc = 0;
  int n_cmp = 0, n_bad = 0;
  int a_on = 0, a_k = 0, a_md = 0, a_outs = 0, a_dones = 0;
  int b_on = 0, b_k = 0, b_md = 0, b_outs = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Row memories with one cycle of read latency.
  always @(posedge clk) begin
    for (int k = 0; k < NA; k++) begin
      x_data_a[k*DWA +: DWA] <= DWA'(xm_a[x_addr_a][k]);
      c_data_a[k*DWA +: DWA] <= DWA'(cm_a[c_addr_a][k]);
    end
    for (int k = 0; k < NB; k++) begin
      x_data_b[k*DWB +: DWB] <= DWB'(xm_b[x_addr_b][k]);
      c_data_b[k*DWB +: DWB] <= DWB'(cm_b[c_addr_b][k]);
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic longint satsh(input longint v, input int sh, input int dw);
    longint r, mx;
    r  = v >>> sh;
    mx = (longint'(1) <<< (dw-1)) - 1;
    if (r > mx) return mx;
    if (r < -mx-1) return -mx-1;
    return r;
  endfunction

  task automatic model(input int n, input int dw, input int sh, input int md,
                       input longint x[16][16], input longint c[16][16],
                       output longint y[16][16]);
    longint p[16][16], t[16][16], s;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        s = 0;
        for (int k = 0; k < n; k++) s += x[i][k] * c[j][k];
        p[i][j] = satsh(s, sh, dw);
        t[j][i] = p[i][j];
      end
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        s = 0;
        for (int k = 0; k < n; k++) s += t[i][k] * c[j][k];
        y[i][j] = md ? p[i][j] : satsh(s, sh, dw);
      end
  endtask

  // Instance A: every cycle of a transform is checked against the expected schedule.
  always @(negedge clk) begin
    int off, tot, fy, idx, ec;
    if (done_a) a_dones++;
    if (y_valid_a) a_outs++;
    if (a_on != 0) begin
      off = cyc - a_k;
      tot = a_md ? NA*NA + 3 : 2*NA*NA + 5;
      fy  = a_md ? 3 : NA*NA + 5;
      chk("a_busy", busy_a, longint'(off >= 1 && off <= tot));
      chk("a_done", done_a, longint'(off == tot));
      chk("a_y_valid", y_valid_a, longint'(off >= fy && off < fy + NA*NA));
      if (y_valid_a && off >= fy && off < fy + NA*NA) begin
        idx = off - fy;
        chk("a_y_row", y_row_a, idx / NA);
        chk("a_y_col", y_col_a, idx % NA);
        chk("a_y_data", $signed(y_data_a), ey_a[idx/NA][idx%NA]);
      end
      chk("a_x_addr", x_addr_a, (off >= 1 && off <= NA*NA) ? (off-1)/NA : 0);
      if (off >= 1 && off <= NA*NA) ec = (off-1) % NA;
      else if (!a_md && off >= NA*NA+3 && off <= 2*NA*NA+2) ec = (off-NA*NA-3) % NA;
      else ec = 0;
      chk("a_c_addr", c_addr_a, ec);
      if (off > tot + 2) a_on = 0;
    end
  end

  // Instance B: output order, values and done timing.
  always @(negedge clk) begin
    if (b_on != 0) begin
      if (y_valid_b) begin
        chk("b_y_row", y_row_b, b_outs / NB);
        chk("b_y_col", y_col_b, b_outs % NB);
        chk("b_y_data", $signed(y_data_b), ey_b[b_outs/NB][b_outs%NB]);
        b_outs++;
      end
      if (done_b) begin
        chk("b_done_cycle", cyc - b_k, b_md ? NB*NB + 3 : 2*NB*NB + 5);
        chk("b_out_count", b_outs, NB*NB);
        b_on = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic run_a(input int md, input int restart_at);
    model(NA, DWA, SHA, md, xm_a, cm_a, ey_a);
    start_a = 1'b1; mode_a = md[0];
    a_k = cyc; a_md = md; a_outs = 0; a_dones = 0; a_on = 1;
    tick(1);
    start_a = 1'b0; mode_a = !md[0];
    if (restart_at > 0) begin
      tick(restart_at - 1);
      start_a = 1'b1;
      tick(1);
      start_a = 1'b0;
    end
    for (int t = 0; t < 400 && a_on != 0; t++) tick(1);
    chk("a_timeout", a_on, 0);
    a_on = 0;
    chk("a_out_count", a_outs, NA*NA);
    chk("a_done_count", a_dones, 1);
  endtask

  task automatic run_b(input int md);
    model(NB, DWB, SHB, md, xm_b, cm_b, ey_b);
    start_b = 1'b1; mode_b = md[0];
    b_k = cyc; b_md = md; b_outs = 0; b_on = 1;
    tick(1);
    start_b = 1'b0; mode_b = !md[0];
    for (int t = 0; t < 200 && b_on != 0; t++) tick(1);
    chk("b_timeout", b_on, 0);
    b_on = 0;
  endtask

  task automatic fill_a(input int kind);
    for (int i = 0; i < NA; i++)
      for (int k = 0; k < NA; k++) begin
        case (kind)
          0: begin xm_a[i][k] = 8*i + k; cm_a[i][k] = (i == k) ? 1 : 0; end
          1: begin xm_a[i][k] = 127; cm_a[i][k] = 127; end
          2: begin xm_a[i][k] = -128; cm_a[i][k] = 127; end
          3: begin xm_a[i][k] = longint'($urandom_range(6)) - 3; cm_a[i][k] = longint'($urandom_range(6)) - 3; end
          default: begin xm_a[i][k] = longint'($urandom_range(255)) - 128; cm_a[i][k] = longint'($urandom_range(255)) - 128; end
        endcase
      end
  endtask

  initial begin
    int snap_o;
    rst = 1'b1; start_a = 1'b0; mode_a = 1'b0; start_b = 1'b0; mode_b = 1'b0;
    for (int i = 0; i < 16; i++)
      for (int k = 0; k < 16; k++) begin
        xm_a[i][k] = 0; cm_a[i][k] = 0; xm_b[i][k] = 0; cm_b[i][k] = 0;
      end
    tick(3);
    @(negedge clk);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_y_valid", y_valid_a, 0);
    chk("rst_y_row", y_row_a, 0);
    chk("rst_y_col", y_col_a, 0);
    chk("rst_y_data", y_data_a, 0);
    chk("rst_x_addr", x_addr_a, 0);
    chk("rst_c_addr", c_addr_a, 0);
    chk("rst_b_busy", busy_b, 0);
    chk("rst_b_y_valid", y_valid_b, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick(2);

    chk("model_sat_hi", satsh(5000, 0, 8), 127);
    chk("model_shift_floor", satsh(-3, 1, 8), -2);

    // Identity C: two-pass gives X^T, single-pass gives X.
    fill_a(0);
    model(NA, DWA, SHA, 0, xm_a, cm_a, ey_a);
    chk("model_two_pass_y52", ey_a[5][2], 21);
    run_a(0, 0);
    model(NA, DWA, SHA, 1, xm_a, cm_a, ey_a);
    chk("model_one_pass_y25", ey_a[2][5], 21);
    run_a(1, 0);

    // Saturation at both rails.
    fill_a(1);
    model(NA, DWA, SHA, 0, xm_a, cm_a, ey_a);
    chk("model_sat_pos", ey_a[3][4], 127);
    run_a(0, 0);
    fill_a(2);
    model(NA, DWA, SHA, 0, xm_a, cm_a, ey_a);
    chk("model_sat_neg", ey_a[6][1], -128);
    run_a(0, 0);

    // A second start while busy must be ignored.
    fill_a(0);
    run_a(0, 10);

    // Reset in the middle of the second pass.
    fill_a(3);
    model(NA, DWA, SHA, 0, xm_a, cm_a, ey_a);
    start_a = 1'b1; mode_a = 1'b0;
    a_k = cyc; a_md = 0; a_outs = 0; a_dones = 0; a_on = 1;
    tick(1);
    start_a = 1'b0;
    for (int t = 0; t < 400 && a_outs < 20; t++) tick(1);
    chk("rst_mid_reached_20", longint'(a_outs >= 20), 1);
    a_on = 0;
    rst = 1'b1;
    tick(1);
    @(negedge clk);
    chk("rst_mid_busy", busy_a, 0);
    chk("rst_mid_y_valid", y_valid_a, 0);
    chk("rst_mid_done", done_a, 0);
    snap_o = a_outs;
    @(posedge clk); #1;
    rst = 1'b0;
    tick(2*NA*NA + 20);
    chk("rst_mid_no_more_outputs", a_outs, snap_o);
    chk("rst_mid_no_done", a_dones, 0);
    run_a(0, 0);

    // Random data on the default-size instance.
    fill_a(3);
    run_a(0, 0);
    fill_a(4);
    run_a(1, 0);

    // Random data on the narrow, shifted instance.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NB; i++)
        for (int k = 0; k < NB; k++) begin
          xm_b[i][k] = longint'($urandom_range(4095)) - 2048;
          cm_b[i][k] = longint'($urandom_range(4095)) - 2048;
        end
      run_b((r == 3) ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
